// File: rtl/css_pkg.sv
// Shared encodings for the syndrome round controller: axes, FSM states and
// the per-axis syndrome-to-correction lookup tables.
package css_pkg;

    localparam logic [1:0] AXIS_NONE = 2'b00;
    localparam logic [1:0] AXIS_X    = 2'b01;
    localparam logic [1:0] AXIS_Y    = 2'b10;
    localparam logic [1:0] AXIS_Z    = 2'b11;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_MEAS   = 3'd1;
    localparam logic [2:0] ST_VOTE   = 3'd2;
    localparam logic [2:0] ST_DECODE = 3'd3;
    localparam logic [2:0] ST_ISSUE  = 3'd4;
    localparam logic [2:0] ST_NEXT   = 3'd5;

    function automatic logic [4:0] x_table(input logic [3:0] syn);
        case (syn)
            4'b0001: x_table = 5'b10000;
            4'b1000: x_table = 5'b01000;
            4'b1100: x_table = 5'b00100;
            4'b0110: x_table = 5'b00010;
            4'b0011: x_table = 5'b00001;
            default: x_table = 5'b00000;
        endcase
    endfunction

    function automatic logic [4:0] y_table(input logic [3:0] syn);
        case (syn)
            4'b1011: y_table = 5'b10000;
            4'b1101: y_table = 5'b01000;
            4'b1110: y_table = 5'b00100;
            4'b1111: y_table = 5'b00010;
            4'b0111: y_table = 5'b00001;
            default: y_table = 5'b00000;
        endcase
    endfunction

    function automatic logic [4:0] z_table(input logic [3:0] syn);
        case (syn)
            4'b1010: z_table = 5'b10000;
            4'b0101: z_table = 5'b01000;
            4'b0010: z_table = 5'b00100;
            4'b1001: z_table = 5'b00010;
            4'b0100: z_table = 5'b00001;
            default: z_table = 5'b00000;
        endcase
    endfunction

endpackage

// File: rtl/css_syndrome_decode.sv
// Combinational syndrome lookup; the controller registers the result.
module css_syndrome_decode
    import css_pkg::*;
(
    input  logic [1:0] axis,
    input  logic [3:0] syndrome,
    output logic [4:0] correction
);

    always_comb begin
        correction = 5'b00000;
        case (axis)
            AXIS_X:  correction = x_table(syndrome);
            AXIS_Y:  correction = y_table(syndrome);
            AXIS_Z:  correction = z_table(syndrome);
            default: correction = 5'b00000;
        endcase
    end

endmodule

// File: rtl/syndrome_round_controller.sv
// Runs one X->Y->Z round: repeated ancilla sampling, majority vote,
// table decode and a valid/ready handoff of each nonzero correction.
module syndrome_round_controller
    import css_pkg::*;
#(
    parameter int NREP = 3
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       start,
    output logic       meas_req,
    output logic [1:0] meas_axis,
    input  logic       meas_valid,
    input  logic [3:0] ancilla,
    output logic       corr_valid,
    input  logic       corr_ready,
    output logic [1:0] corr_axis,
    output logic [4:0] correction,
    output logic       busy,
    output logic       vote_err
);

    logic [2:0] state;
    logic [1:0] axis_q;
    logic [2:0] ones_cnt [4];
    logic [2:0] smp_cnt;
    logic [3:0] syn_q;
    logic [4:0] corr_q;
    logic       err_q;
    logic [3:0] voted;
    logic       mixed;
    logic [4:0] dec_corr;

    // A bit is "mixed" when its samples were neither all-zero nor all-one.
    always_comb begin
        voted = 4'b0000;
        mixed = 1'b0;
        for (int i = 0; i < 4; i++) begin
            voted[i] = (ones_cnt[i] > 3'(NREP / 2));
            if (ones_cnt[i] != 3'd0 && ones_cnt[i] != 3'(NREP))
                mixed = 1'b1;
        end
    end

    css_syndrome_decode u_decode (
        .axis       (axis_q),
        .syndrome   (syn_q),
        .correction (dec_corr)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= ST_IDLE;
            axis_q  <= AXIS_NONE;
            smp_cnt <= 3'd0;
            syn_q   <= 4'b0000;
            corr_q  <= 5'b00000;
            err_q   <= 1'b0;
            for (int i = 0; i < 4; i++) ones_cnt[i] <= 3'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_MEAS;
                        axis_q  <= AXIS_X;
                        err_q   <= 1'b0;
                        smp_cnt <= 3'd0;
                        for (int i = 0; i < 4; i++) ones_cnt[i] <= 3'd0;
                    end
                end
                ST_MEAS: begin
                    if (meas_valid) begin
                        for (int i = 0; i < 4; i++)
                            ones_cnt[i] <= ones_cnt[i] + {2'b00, ancilla[i]};
                        if (smp_cnt == 3'(NREP - 1)) begin
                            smp_cnt <= 3'd0;
                            state   <= ST_VOTE;
                        end else begin
                            smp_cnt <= smp_cnt + 3'd1;
                        end
                    end
                end
                ST_VOTE: begin
                    syn_q <= voted;
                    if (mixed) err_q <= 1'b1;
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    corr_q <= dec_corr;
                    state  <= (dec_corr != 5'b00000) ? ST_ISSUE : ST_NEXT;
                end
                ST_ISSUE: begin
                    if (corr_ready) state <= ST_NEXT;
                end
                ST_NEXT: begin
                    for (int i = 0; i < 4; i++) ones_cnt[i] <= 3'd0;
                    if (axis_q == AXIS_Z) begin
                        axis_q <= AXIS_NONE;
                        state  <= ST_IDLE;
                    end else begin
                        axis_q <= axis_q + 2'd1;
                        state  <= ST_MEAS;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign meas_req   = (state == ST_MEAS);
    assign meas_axis  = axis_q;
    assign corr_valid = (state == ST_ISSUE);
    assign correction = corr_valid ? corr_q : 5'b00000;
    assign corr_axis  = corr_valid ? axis_q : AXIS_NONE;
    assign busy       = (state != ST_IDLE);
    assign vote_err   = err_q;

endmodule

// File: tb/tb_syndrome_round_controller.sv
// Randomized bench for syndrome_round_controller with a counting-based
// majority/table reference model.
module tb_syndrome_round_controller;

    localparam int NREP = 3;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       start = 1'b0;
    logic       meas_valid = 1'b0;
    logic       corr_ready = 1'b0;
    logic [3:0] ancilla = 4'b0000;
    logic       meas_req, corr_valid, busy, vote_err;
    logic [1:0] meas_axis, corr_axis;
    logic [4:0] correction;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    syndrome_round_controller #(.NREP(NREP)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .start      (start),
        .meas_req   (meas_req),
        .meas_axis  (meas_axis),
        .meas_valid (meas_valid),
        .ancilla    (ancilla),
        .corr_valid (corr_valid),
        .corr_ready (corr_ready),
        .corr_axis  (corr_axis),
        .correction (correction),
        .busy       (busy),
        .vote_err   (vote_err)
    );

    // Syndrome tables: entry k of an axis maps to one-hot 10000 >> k.
    logic [3:0] tbl [3][5];

    logic [3:0] smp [3][NREP];
    int         rdy_delay [3];
    bit         spam_start;

    int         idx [3];
    int         vcyc [3];
    int         lat [3];
    int         last_neg [3];
    logic [4:0] obs_corr [3];
    int         first_axis;
    bit         timeout, extra, bad_axis, unstable;
    logic       obs_err;
    logic [1:0] end_axis;
    logic       end_valid;

    logic [4:0] exp_corr [3];
    logic       exp_err;

    task automatic compute_expected();
        logic [3:0] v;
        int ones;
        exp_err = 1'b0;
        for (int a = 0; a < 3; a++) begin
            v = 4'b0000;
            for (int b = 0; b < 4; b++) begin
                ones = 0;
                for (int r = 0; r < NREP; r++) ones += int'(smp[a][r][b]);
                if (2 * ones > NREP) v[b] = 1'b1;
                if (ones != 0 && ones != NREP) exp_err = 1'b1;
            end
            exp_corr[a] = 5'b00000;
            for (int k = 0; k < 5; k++)
                if (tbl[a][k] == v) exp_corr[a] = 5'b10000 >> k;
        end
    endtask

    task automatic set_axis(input int a, input logic [3:0] s);
        for (int r = 0; r < NREP; r++) smp[a][r] = s;
    endtask

    // Drives one full round as measurement source and correction consumer,
    // recording what the DUT did.
    task automatic run_round();
        int a;
        int cyc;
        for (int i = 0; i < 3; i++) begin
            idx[i] = 0; vcyc[i] = 0; lat[i] = -1; last_neg[i] = 0; obs_corr[i] = 5'b0;
        end
        first_axis = 0; timeout = 0; extra = 0; bad_axis = 0; unstable = 0;
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
        cyc = 0;
        while (busy && cyc < 300) begin
            meas_valid = 1'b0;
            corr_ready = 1'b0;
            ancilla = 4'($urandom);
            if (meas_req) begin
                if (meas_axis == 2'b00) bad_axis = 1;
                else begin
                    a = int'(meas_axis) - 1;
                    if (first_axis == 0) first_axis = int'(meas_axis);
                    if (idx[a] >= NREP) extra = 1;
                    else if ($urandom_range(0, 3) != 0) begin
                        meas_valid = 1'b1;
                        ancilla = smp[a][idx[a]];
                        idx[a]++;
                        if (idx[a] == NREP) last_neg[a] = cyc;
                    end
                end
            end else if ($urandom_range(0, 2) == 0) begin
                meas_valid = 1'b1;
            end
            if (corr_valid) begin
                if (corr_axis == 2'b00) bad_axis = 1;
                else begin
                    a = int'(corr_axis) - 1;
                    if (vcyc[a] == 0) begin
                        obs_corr[a] = correction;
                        lat[a] = cyc - last_neg[a];
                    end else if (correction !== obs_corr[a]) unstable = 1;
                    vcyc[a]++;
                    if (vcyc[a] > rdy_delay[a]) corr_ready = 1'b1;
                end
            end else if ($urandom_range(0, 1) == 0) begin
                corr_ready = 1'b1;
            end
            if (spam_start) start = 1'($urandom_range(0, 1));
            cyc++;
            @(negedge CLK);
        end
        start = 1'b0; meas_valid = 1'b0; corr_ready = 1'b0;
        if (busy) timeout = 1;
        obs_err   = vote_err;
        end_axis  = meas_axis;
        end_valid = corr_valid;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        n_tests++;
        if ({meas_req, meas_axis, corr_valid, corr_axis, correction, busy, vote_err} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 0", {meas_req, meas_axis, corr_valid, corr_axis, correction, busy, vote_err});
        end
        RST_N = 1'b1;
        @(negedge CLK);
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_x_clean();
        set_axis(0, 4'b0011); set_axis(1, 4'b0000); set_axis(2, 4'b0000);
        rdy_delay = '{0, 0, 0}; spam_start = 0;
        compute_expected();
        run_round();
        n_tests++;
        if (timeout) begin n_fail++; $display("FAIL x_timeout: busy still %b want 0", busy); end
        n_tests++;
        if (vcyc[0] != 1 || obs_corr[0] !== 5'b00001) begin
            n_fail++; $display("FAIL x_correction: got %b (%0d cycles) want 00001 (1 cycle)", obs_corr[0], vcyc[0]);
        end
        n_tests++;
        if (lat[0] != 3) begin n_fail++; $display("FAIL x_latency: got %0d want 3", lat[0]); end
        n_tests++;
        if (vcyc[1] != 0 || vcyc[2] != 0) begin
            n_fail++; $display("FAIL x_yz_silent: got %0d/%0d valid cycles want 0/0", vcyc[1], vcyc[2]);
        end
        n_tests++;
        if (obs_err !== 1'b0) begin n_fail++; $display("FAIL x_vote_err: got %b want 0", obs_err); end
    endtask

    task automatic test_y_disagree();
        set_axis(0, 4'b0000); set_axis(2, 4'b0000);
        smp[1][0] = 4'b1111; smp[1][1] = 4'b1111; smp[1][2] = 4'b0111;
        rdy_delay = '{0, 1, 0}; spam_start = 0;
        run_round();
        n_tests++;
        if (vcyc[1] != 2 || obs_corr[1] !== 5'b00010) begin
            n_fail++; $display("FAIL y_correction: got %b (%0d cycles) want 00010 (2 cycles)", obs_corr[1], vcyc[1]);
        end
        n_tests++;
        if (obs_err !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL y_vote_err_idle: got err=%b busy=%b want err=1 busy=0", obs_err, busy);
        end
        @(negedge CLK);
        n_tests++;
        if (vote_err !== 1'b1) begin n_fail++; $display("FAIL y_vote_err_sticky: got %b want 1", vote_err); end
    endtask

    task automatic test_all_zero();
        set_axis(0, 4'b0000); set_axis(1, 4'b0000); set_axis(2, 4'b0000);
        rdy_delay = '{0, 0, 0}; spam_start = 0;
        run_round();
        n_tests++;
        if (vcyc[0] + vcyc[1] + vcyc[2] != 0) begin
            n_fail++; $display("FAIL zero_no_valid: got %0d valid cycles want 0", vcyc[0] + vcyc[1] + vcyc[2]);
        end
        n_tests++;
        if (timeout || end_axis !== 2'b00 || obs_err !== 1'b0) begin
            n_fail++; $display("FAIL zero_end: got timeout=%0d axis=%b err=%b want 0/00/0", timeout, end_axis, obs_err);
        end
        n_tests++;
        if (idx[0] != NREP || idx[1] != NREP || idx[2] != NREP || extra) begin
            n_fail++; $display("FAIL zero_samples: got %0d/%0d/%0d extra=%0d want %0d each", idx[0], idx[1], idx[2], extra, NREP);
        end
    endtask

    task automatic test_z_backpressure();
        set_axis(0, 4'b0000); set_axis(1, 4'b0000); set_axis(2, 4'b1010);
        rdy_delay = '{0, 0, 5}; spam_start = 0;
        run_round();
        n_tests++;
        if (vcyc[2] != 6 || obs_corr[2] !== 5'b10000 || unstable) begin
            n_fail++; $display("FAIL z_backpressure: got %b over %0d cycles unstable=%0d want 10000 over 6", obs_corr[2], vcyc[2], unstable);
        end
    endtask

    task automatic test_reset_in_issue();
        int cyc;
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
        cyc = 0;
        while (!corr_valid && cyc < 60) begin
            meas_valid = meas_req;
            ancilla = 4'b0001;
            corr_ready = 1'b0;
            cyc++;
            @(negedge CLK);
        end
        meas_valid = 1'b0;
        n_tests++;
        if (corr_valid !== 1'b1 || correction !== 5'b10000) begin
            n_fail++; $display("FAIL rst_pre_issue: got valid=%b corr=%b want 1/10000", corr_valid, correction);
        end
        #2 RST_N = 1'b0;
        #1;
        n_tests++;
        if ({meas_req, meas_axis, corr_valid, corr_axis, correction, busy, vote_err} !== 13'd0) begin
            n_fail++; $display("FAIL rst_async: got %b want 0", {meas_req, meas_axis, corr_valid, corr_axis, correction, busy, vote_err});
        end
        @(negedge CLK); RST_N = 1'b1;
        set_axis(0, 4'b1100); set_axis(1, 4'b0000); set_axis(2, 4'b0000);
        rdy_delay = '{2, 0, 0}; spam_start = 0;
        run_round();
        n_tests++;
        if (first_axis != 1 || obs_corr[0] !== 5'b00100 || timeout) begin
            n_fail++; $display("FAIL rst_fresh_round: got axis=%0d corr=%b timeout=%0d want 1/00100/0", first_axis, obs_corr[0], timeout);
        end
    endtask

    task automatic test_ignore();
        int bad;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            meas_valid = 1'b1; ancilla = 4'b1111;
            @(negedge CLK);
            if (busy || meas_req) bad++;
        end
        meas_valid = 1'b0;
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL idle_meas_valid: got %0d busy cycles want 0", bad); end
        set_axis(0, 4'b0001); set_axis(1, 4'b0000); set_axis(2, 4'b0000);
        rdy_delay = '{1, 0, 0}; spam_start = 1;
        run_round();
        spam_start = 0;
        n_tests++;
        if (obs_corr[0] !== 5'b10000 || obs_err !== 1'b0) begin
            n_fail++; $display("FAIL ignore_counts: got corr=%b err=%b want 10000/0", obs_corr[0], obs_err);
        end
        n_tests++;
        if (timeout || extra || first_axis != 1 || idx[1] != NREP || idx[2] != NREP) begin
            n_fail++; $display("FAIL ignore_restart: got timeout=%0d extra=%0d y=%0d z=%0d want 0/0/%0d/%0d", timeout, extra, idx[1], idx[2], NREP, NREP);
        end
    endtask

    task automatic test_random();
        logic [3:0] base;
        for (int n = 0; n < 20; n++) begin
            for (int a = 0; a < 3; a++) begin
                base = ($urandom_range(0, 1) == 0) ? tbl[a][$urandom_range(0, 4)] : 4'($urandom);
                for (int r = 0; r < NREP; r++) begin
                    smp[a][r] = base;
                    if ($urandom_range(0, 3) == 0) smp[a][r][$urandom_range(0, 3)] ^= 1'b1;
                end
                rdy_delay[a] = $urandom_range(0, 3);
            end
            spam_start = 1'($urandom_range(0, 1));
            compute_expected();
            run_round();
            for (int a = 0; a < 3; a++) begin
                n_tests++;
                if (exp_corr[a] == 5'b0 ? (vcyc[a] != 0)
                    : (obs_corr[a] !== exp_corr[a] || vcyc[a] != rdy_delay[a] + 1 || lat[a] != 3)) begin
                    n_fail++;
                    $display("FAIL rand_axis%0d: got corr=%b cycles=%0d lat=%0d want corr=%b cycles=%0d lat=3",
                             a + 1, obs_corr[a], vcyc[a], lat[a], exp_corr[a], exp_corr[a] == 5'b0 ? 0 : rdy_delay[a] + 1);
                end
            end
            n_tests++;
            if (obs_err !== exp_err || timeout || extra || bad_axis || unstable || end_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_round: got err=%b timeout=%0d extra=%0d badaxis=%0d unstable=%0d want err=%b clean",
                         obs_err, timeout, extra, bad_axis, unstable, exp_err);
            end
            spam_start = 0;
        end
    endtask

    initial begin
        tbl[0] = '{4'b0001, 4'b1000, 4'b1100, 4'b0110, 4'b0011};
        tbl[1] = '{4'b1011, 4'b1101, 4'b1110, 4'b1111, 4'b0111};
        tbl[2] = '{4'b1010, 4'b0101, 4'b0010, 4'b1001, 4'b0100};
        spam_start = 0;
        test_reset();
        test_x_clean();
        test_y_disagree();
        test_all_zero();
        test_z_backpressure();
        test_reset_in_issue();
        test_ignore();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
